// File: rtl/serial_addsub_mag.sv
// Digit-serial unsigned add/subtract unit with valid/ready handshakes.
// Optional feature macro: ALU_SUB_MAGNITUDE_EN (returns magnitude of negative differences).
module serial_addsub_mag #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
`ifdef ALU_SUB_MAGNITUDE_EN
        FIX  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
`ifdef ALU_SUB_MAGNITUDE_EN
    logic             sub_q, sub_d;
`endif
    logic [DIGIT:0]   sum_w;

    // Digit slice: low digit of the shifting operands plus the running carry
    always_comb begin
        sum_w = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
              + (DIGIT+1)'(carry_q);
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef ALU_SUB_MAGNITUDE_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub;
                    cnt_d   = '0;
`ifdef ALU_SUB_MAGNITUDE_EN
                    sub_d   = op_sub;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                s_d     = (s_q >> DIGIT)
                        | (WIDTH'(sum_w[DIGIT-1:0]) << (WIDTH - DIGIT));
                carry_d = sum_w[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = sum_w[DIGIT];
                    cnt_d   = '0;
`ifdef ALU_SUB_MAGNITUDE_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef ALU_SUB_MAGNITUDE_EN
            FIX: begin
                if (sub_q && !carry_q) begin
                    s_d = ~s_q + WIDTH'(1);
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef ALU_SUB_MAGNITUDE_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef ALU_SUB_MAGNITUDE_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_s     = s_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_serial_addsub_mag.sv
// Testbench for serial_addsub_mag: directed and random ops vs. arithmetic model.
// Covers both 16/4 and 8/1 configurations; honours ALU_SUB_MAGNITUDE_EN.
module tb_serial_addsub_mag;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        in_valid, in_ready, op_sub;
    logic [15:0] a, b, out_s;
    logic        out_valid, out_ready, out_cout;

    logic        in_valid8, in_ready8, op_sub8;
    logic [7:0]  a8, b8, out_s8;
    logic        out_valid8, out_ready8, out_cout8;

    int tests = 0;
    int fails = 0;

`ifdef ALU_SUB_MAGNITUDE_EN
    localparam int MAG = 1;
`else
    localparam int MAG = 0;
`endif

    serial_addsub_mag #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_cout(out_cout)
    );

    serial_addsub_mag #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid8), .in_ready(in_ready8), .op_sub(op_sub8),
        .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_s(out_s8), .out_cout(out_cout8)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain-arithmetic reference: modular sum, borrow-free flag, magnitude
    function automatic void model(input bit sub, input int unsigned x,
                                  input int unsigned y, input int w,
                                  output int unsigned s, output bit c);
        longint unsigned m;
        longint unsigned t;
        m = 64'd1 << w;
        if (!sub) begin
            t = longint'(x) + longint'(y);
            c = (t >= m);
            t = t % m;
        end else begin
            c = (x >= y);
            t = (longint'(x) + m - longint'(y)) % m;
            if (MAG == 1 && !c) t = longint'(y) - longint'(x);
        end
        s = int'(t);
    endfunction

    task automatic run_op(input bit w8, input bit sub, input int unsigned x,
                          input int unsigned y, input int hold,
                          input string tag);
        int unsigned es;
        bit          ec;
        int          lat;
        int          n;
        model(sub, x, y, w8 ? 8 : 16, es, ec);
        n = (w8 ? 8 : 4) + MAG;
        lat = 0;
        while (!(w8 ? in_ready8 : in_ready) && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, " in_ready"}, w8 ? in_ready8 : in_ready, 1);
        if (w8) begin
            in_valid8 = 1'b1; op_sub8 = sub; a8 = x[7:0]; b8 = y[7:0];
        end else begin
            in_valid = 1'b1; op_sub = sub; a = x[15:0]; b = y[15:0];
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        lat = 0;
        while (!(w8 ? out_valid8 : out_valid) && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, " latency"}, lat, n);
        check({tag, " out_s"}, w8 ? out_s8 : out_s, es);
        check({tag, " out_cout"}, w8 ? out_cout8 : out_cout, ec);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, w8 ? out_valid8 : out_valid, 1);
            check({tag, " hold s"}, w8 ? out_s8 : out_s, es);
            check({tag, " hold cout"}, w8 ? out_cout8 : out_cout, ec);
            check({tag, " hold in_ready"}, w8 ? in_ready8 : in_ready, 0);
        end
        if (w8) out_ready8 = 1'b1;
        else    out_ready  = 1'b1;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        out_ready8 = 1'b0;
        check({tag, " post in_ready"}, w8 ? in_ready8 : in_ready, 1);
        check({tag, " post valid"}, w8 ? out_valid8 : out_valid, 0);
    endtask

    initial begin
        resetn     = 1'b0;
        in_valid   = 1'b0; op_sub  = 1'b0; a  = '0; b  = '0;
        out_ready  = 1'b0;
        in_valid8  = 1'b0; op_sub8 = 1'b0; a8 = '0; b8 = '0;
        out_ready8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst out_s", out_s, 0);
        check("rst out_cout", out_cout, 0);
        check("rst8 in_ready", in_ready8, 1);
        check("rst8 out_s", out_s8, 0);

        run_op(1'b0, 1'b1, 32'h1234, 32'h0234, 0, "sub1");
        run_op(1'b0, 1'b1, 32'h0005, 32'h0009, 0, "sub_neg");
        run_op(1'b0, 1'b0, 32'hFFFF, 32'h0001, 0, "add_ovf");
        run_op(1'b0, 1'b1, 32'h8000, 32'h8000, 0, "sub_eq");
        run_op(1'b0, 1'b0, 32'h1111, 32'h2222, 3, "hold");
        run_op(1'b0, 1'b1, 32'h0100, 32'h0001, 0, "b2b");

        // Abort an operation with reset while digit 2 is being processed
        in_valid = 1'b1; op_sub = 1'b1; a = 16'h1234; b = 16'h0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort out_s", out_s, 0);
        check("abort out_cout", out_cout, 0);
        run_op(1'b0, 1'b1, 32'h0003, 32'h0001, 0, "after_abort");

        run_op(1'b1, 1'b1, 32'h00, 32'h01, 0, "w8_sub_neg");
        run_op(1'b1, 1'b0, 32'hFF, 32'h01, 0, "w8_add_ovf");

        for (int i = 0; i < 20; i++) begin
            run_op(1'b0, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF,
                   $urandom & 32'hFFFF, 0, "rnd16");
        end
        for (int i = 0; i < 8; i++) begin
            run_op(1'b1, 1'($urandom_range(0, 1)), $urandom & 32'hFF,
                   $urandom & 32'hFF, 0, "rnd8");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
